// File: rtl/change_dispenser_pkg.sv
// Shared coin definitions for the vending datapath (package chg_pkg).
// Also used by the upstream coin-accumulating controller.
package chg_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;
   localparam logic [1:0] COIN_25   = 2'b11;

   localparam int unsigned VAL_5  = 5;
   localparam int unsigned VAL_10 = 10;
   localparam int unsigned VAL_25 = 25;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_EMIT   = 2'd2,
      ST_DONE   = 2'd3
   } chg_state_e;

   function automatic logic [4:0] coin_value(input logic [1:0] code);
      case (code)
         COIN_5:  return 5'd5;
         COIN_10: return 5'd10;
         COIN_25: return 5'd25;
         default: return 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request, coin-eject, refill and completion signals of the change dispenser.
interface change_dispenser_if #(parameter int AMT_W = 8);
   logic             chg_valid;
   logic [AMT_W-1:0] chg_amount;
   logic             chg_ready;
   logic             coin_valid;
   logic [1:0]       coin_code;
   logic             coin_ack;
   logic             refill_valid;
   logic [1:0]       refill_code;
   logic             done;
   logic             short;
   logic             err;
   logic [AMT_W-1:0] remain;

   modport master (
      output chg_valid, chg_amount, coin_ack, refill_valid, refill_code,
      input  chg_ready, coin_valid, coin_code, done, short, err, remain
   );

   modport slave (
      input  chg_valid, chg_amount, coin_ack, refill_valid, refill_code,
      output chg_ready, coin_valid, coin_code, done, short, err, remain
   );
endinterface

// File: rtl/change_dispenser_tube.sv
// One coin tube: inventory counter with reset preload, saturating inc/dec.
module coin_tube #(
   parameter int INV_W    = 6,
   parameter int INV_INIT = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   output logic [INV_W-1:0] cnt,
   output logic             nonempty
);
   localparam logic [INV_W-1:0] INIT = INV_W'(INV_INIT);
   localparam logic [INV_W-1:0] MAX  = '1;

   // Simultaneous refill and eject cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= INIT;
      end else if (inc && !dec) begin
         if (cnt != MAX) cnt <= cnt + INV_W'(1);
      end else if (dec && !inc) begin
         if (cnt != '0) cnt <= cnt - INV_W'(1);
      end
   end

   assign nonempty = (cnt != '0);
endmodule

// File: rtl/change_dispenser.sv
// Greedy 25/10/5 change dispenser limited by tube inventory.
// Optional CHG_AUDIT_EN adds coin-value total and shortfall counters.
module change_dispenser
   import chg_pkg::*;
#(
   parameter int AMT_W    = 8,
   parameter int INV_W    = 6,
   parameter int INV_INIT = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   change_dispenser_if.slave  bus,
   output logic [INV_W-1:0]   inv5,
   output logic [INV_W-1:0]   inv10,
   output logic [INV_W-1:0]   inv25
`ifdef CHG_AUDIT_EN
   ,
   output logic [15:0]        audit_total,
   output logic [7:0]         audit_short_cnt
`endif
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SELECT = 2'd1;
   localparam logic [1:0] S_EMIT   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]             state;
   logic [AMT_W-1:0]       rem;
   logic [1:0]             code_q;
   logic                   short_q, err_q;
   logic [1:0]             pick;
   logic                   hs, coin_fire;
   logic [AMT_W-1:0]       rem_sub;
   logic [2:0]             tube_inc, tube_dec, tube_ne;
   logic [2:0][INV_W-1:0]  tube_cnt;

   assign hs        = bus.chg_valid && (state == S_IDLE);
   assign coin_fire = (state == S_EMIT) && bus.coin_ack;
   assign rem_sub   = rem - AMT_W'(coin_value(code_q));

   // Largest affordable coin that is still in stock.
   always_comb begin
      pick = COIN_NONE;
      if (rem >= AMT_W'(VAL_25) && tube_ne[2])      pick = COIN_25;
      else if (rem >= AMT_W'(VAL_10) && tube_ne[1]) pick = COIN_10;
      else if (rem >= AMT_W'(VAL_5) && tube_ne[0])  pick = COIN_5;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         rem     <= '0;
         code_q  <= COIN_NONE;
         short_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (hs) begin
               rem     <= bus.chg_amount;
               short_q <= 1'b0;
               err_q   <= 1'b0;
               if ((bus.chg_amount % AMT_W'(5)) != '0) begin
                  err_q <= 1'b1;
                  state <= S_DONE;
               end else if (bus.chg_amount == '0) begin
                  state <= S_DONE;
               end else begin
                  state <= S_SELECT;
               end
            end
            S_SELECT: begin
               if (pick == COIN_NONE) begin
                  short_q <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  code_q <= pick;
                  state  <= S_EMIT;
               end
            end
            S_EMIT: if (coin_fire) begin
               rem   <= rem_sub;
               state <= (rem_sub == '0) ? S_DONE : S_SELECT;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.chg_ready  = (state == S_IDLE);
   assign bus.coin_valid = (state == S_EMIT);
   assign bus.coin_code  = (state == S_EMIT) ? code_q : COIN_NONE;
   assign bus.done       = (state == S_DONE);
   assign bus.short      = (state == S_DONE) && short_q;
   assign bus.err        = (state == S_DONE) && err_q;
   assign bus.remain     = (state == S_DONE) ? rem : '0;

   // Tube index i holds the coin whose code is i+1.
   for (genvar i = 0; i < 3; i++) begin : g_tube
      localparam logic [1:0] CODE = 2'(i + 1);
      assign tube_inc[i] = bus.refill_valid && (bus.refill_code == CODE);
      assign tube_dec[i] = coin_fire && (code_q == CODE);
      coin_tube #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_tube (
         .clk      (clk),
         .rst_n    (rst_n),
         .inc      (tube_inc[i]),
         .dec      (tube_dec[i]),
         .cnt      (tube_cnt[i]),
         .nonempty (tube_ne[i])
      );
   end

   assign inv5  = tube_cnt[0];
   assign inv10 = tube_cnt[1];
   assign inv25 = tube_cnt[2];

`ifdef CHG_AUDIT_EN
   logic [16:0] audit_sum;
   assign audit_sum = {1'b0, audit_total} + 17'(coin_value(code_q));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         audit_total     <= '0;
         audit_short_cnt <= '0;
      end else begin
         if (coin_fire) audit_total <= audit_sum[16] ? 16'hFFFF : audit_sum[15:0];
         if (state == S_DONE && short_q) audit_short_cnt <= audit_short_cnt + 8'd1;
      end
   end
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench: vector table on a full-stock dispenser, hand sequences for
// stall/reset/refill, and a second instance preloaded empty for shortfall cases.
module tb_change_dispenser;
   import chg_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0;
   logic       chg_valid = 1'b0;
   logic [7:0] chg_amount = '0;
   logic       coin_ack = 1'b0;
   logic       refill_valid = 1'b0;
   logic [1:0] refill_code = '0;

   always #5 clk = ~clk;

   change_dispenser_if #(.AMT_W(8)) ba ();
   change_dispenser_if #(.AMT_W(8)) bb ();

   assign ba.chg_valid    = chg_valid & ~sel;
   assign ba.chg_amount   = chg_amount;
   assign ba.coin_ack     = coin_ack & ~sel;
   assign ba.refill_valid = refill_valid & ~sel;
   assign ba.refill_code  = refill_code;
   assign bb.chg_valid    = chg_valid & sel;
   assign bb.chg_amount   = chg_amount;
   assign bb.coin_ack     = coin_ack & sel;
   assign bb.refill_valid = refill_valid & sel;
   assign bb.refill_code  = refill_code;

   logic [5:0] a5, a10, a25, b5, b10, b25;
`ifdef CHG_AUDIT_EN
   logic [15:0] a_tot, b_tot;
   logic [7:0]  a_sc, b_sc;
`endif

   change_dispenser #(.AMT_W(8), .INV_W(6), .INV_INIT(10)) dut (
      .clk(clk), .rst_n(rst_n), .bus(ba), .inv5(a5), .inv10(a10), .inv25(a25)
`ifdef CHG_AUDIT_EN
      , .audit_total(a_tot), .audit_short_cnt(a_sc)
`endif
   );

   change_dispenser #(.AMT_W(8), .INV_W(6), .INV_INIT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bb), .inv5(b5), .inv10(b10), .inv25(b25)
`ifdef CHG_AUDIT_EN
      , .audit_total(b_tot), .audit_short_cnt(b_sc)
`endif
   );

   logic       o_ready, o_cv, o_done, o_short, o_err;
   logic [1:0] o_code;
   logic [7:0] o_rem;
   logic [5:0] o_i5, o_i10, o_i25;
   assign o_ready = sel ? bb.chg_ready  : ba.chg_ready;
   assign o_cv    = sel ? bb.coin_valid : ba.coin_valid;
   assign o_code  = sel ? bb.coin_code  : ba.coin_code;
   assign o_done  = sel ? bb.done       : ba.done;
   assign o_short = sel ? bb.short      : ba.short;
   assign o_err   = sel ? bb.err        : ba.err;
   assign o_rem   = sel ? bb.remain     : ba.remain;
   assign o_i5    = sel ? b5  : a5;
   assign o_i10   = sel ? b10 : a10;
   assign o_i25   = sel ? b25 : a25;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   typedef struct {
      logic [7:0] amt;
      int         ncoin;
      logic [1:0] c0, c1, c2;
      logic       sh, er;
      logic [7:0] rm;
      logic [5:0] i25, i10, i5;
   } vec_t;
   vec_t tbl[5];

   logic [1:0] got_codes[8];
   int         got_n, got_lat;
   logic       got_done, got_sh, got_er;
   logic [7:0] got_rm;

   // Issue one request, ack each coin the cycle it appears, stop at done.
   task automatic run_req(input logic [7:0] amt);
      got_n = 0; got_lat = -1; got_done = 0; got_sh = 0; got_er = 0; got_rm = 0;
      for (int k = 0; k < 8; k++) got_codes[k] = COIN_NONE;
      chg_amount = amt;
      chg_valid = 1'b1;
      @(negedge clk);
      chg_valid = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (o_done) begin
            got_done = 1; got_sh = o_short; got_er = o_err; got_rm = o_rem;
            break;
         end
         if (o_cv) begin
            if (got_lat < 0) got_lat = c + 1;
            if (got_n < 8) got_codes[got_n] = o_code;
            got_n++;
            coin_ack = 1'b1;
         end else begin
            coin_ack = 1'b0;
         end
         @(negedge clk);
      end
      coin_ack = 1'b0;
      chk("done_seen", 32'(got_done), 32'd1);
   endtask

   initial begin
      int dcnt;
      tbl[0] = '{8'd45, 3, COIN_25, COIN_10, COIN_10,     1'b0, 1'b0, 8'd0,  6'd9, 6'd8, 6'd10};
      tbl[1] = '{8'd17, 0, COIN_NONE, COIN_NONE, COIN_NONE, 1'b0, 1'b1, 8'd17, 6'd9, 6'd8, 6'd10};
      tbl[2] = '{8'd0,  0, COIN_NONE, COIN_NONE, COIN_NONE, 1'b0, 1'b0, 8'd0,  6'd9, 6'd8, 6'd10};
      tbl[3] = '{8'd40, 3, COIN_25, COIN_10, COIN_5,      1'b0, 1'b0, 8'd0,  6'd8, 6'd7, 6'd9};
      tbl[4] = '{8'd5,  1, COIN_5, COIN_NONE, COIN_NONE,  1'b0, 1'b0, 8'd0,  6'd8, 6'd7, 6'd8};

      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_cv",    32'(o_cv),    32'd0);
      chk("rst_code",  32'(o_code),  32'd0);
      chk("rst_done",  32'(o_done),  32'd0);
      chk("rst_rem",   32'(o_rem),   32'd0);
      chk("rst_inv25", 32'(o_i25),   32'd10);
      chk("rst_inv5",  32'(o_i5),    32'd10);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_req(tbl[i].amt);
         chk($sformatf("v%0d_ncoin", i), 32'(got_n), 32'(tbl[i].ncoin));
         if (tbl[i].ncoin > 0) chk($sformatf("v%0d_c0", i), 32'(got_codes[0]), 32'(tbl[i].c0));
         if (tbl[i].ncoin > 1) chk($sformatf("v%0d_c1", i), 32'(got_codes[1]), 32'(tbl[i].c1));
         if (tbl[i].ncoin > 2) chk($sformatf("v%0d_c2", i), 32'(got_codes[2]), 32'(tbl[i].c2));
         chk($sformatf("v%0d_short", i), 32'(got_sh), 32'(tbl[i].sh));
         chk($sformatf("v%0d_err", i),   32'(got_er), 32'(tbl[i].er));
         chk($sformatf("v%0d_remain", i), 32'(got_rm), 32'(tbl[i].rm));
         if (i == 0) chk("first_coin_latency", 32'(got_lat), 32'd2);
         @(negedge clk);
         chk($sformatf("v%0d_ready_back", i), 32'(o_ready), 32'd1);
         chk($sformatf("v%0d_inv25", i), 32'(o_i25), 32'(tbl[i].i25));
         chk($sformatf("v%0d_inv10", i), 32'(o_i10), 32'(tbl[i].i10));
         chk($sformatf("v%0d_inv5", i),  32'(o_i5),  32'(tbl[i].i5));
`ifdef CHG_AUDIT_EN
         if (i == 0) chk("audit_total_45", 32'(a_tot), 32'd45);
`endif
      end

      // Stall: ack held low, coin must stay put; then reset mid-hold.
      chg_amount = 8'd25;
      chg_valid = 1'b1;
      @(negedge clk);
      chg_valid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", 32'(o_cv), 32'd1);
         chk("stall_code",  32'(o_code), 32'(COIN_25));
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_cv",    32'(o_cv),    32'd0);
      chk("midrst_code",  32'(o_code),  32'd0);
      chk("midrst_ready", 32'(o_ready), 32'd1);
      chk("midrst_done",  32'(o_done),  32'd0);
      chk("midrst_inv25", 32'(o_i25),   32'd10);
      chk("midrst_inv10", 32'(o_i10),   32'd10);
      @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (o_done) dcnt++;
      end
      chk("midrst_no_done", 32'(dcnt), 32'd0);

      // Refill the 10 tube in the same cycle its coin is acked.
      chg_amount = 8'd10;
      chg_valid = 1'b1;
      @(negedge clk);
      chg_valid = 1'b0;
      @(negedge clk);
      chk("rf_cv",   32'(o_cv),   32'd1);
      chk("rf_code", 32'(o_code), 32'(COIN_10));
      coin_ack = 1'b1;
      refill_valid = 1'b1;
      refill_code = COIN_10;
      @(negedge clk);
      coin_ack = 1'b0;
      refill_valid = 1'b0;
      chk("rf_inv10_same", 32'(o_i10), 32'd10);
      chk("rf_done",       32'(o_done), 32'd1);
      refill_valid = 1'b1;
      @(negedge clk);
      refill_valid = 1'b0;
      chk("rf_inv10_inc", 32'(o_i10), 32'd11);

      // Empty-preload instance: stock only 10s and 5s.
      sel = 1'b1;
      @(negedge clk);
      chk("e_inv25", 32'(o_i25), 32'd0);
      refill_valid = 1'b1;
      refill_code = COIN_10;
      repeat (3) @(negedge clk);
      refill_code = COIN_5;
      @(negedge clk);
      refill_valid = 1'b0;
      refill_code = COIN_NONE;
      chk("e_inv10", 32'(o_i10), 32'd3);
      chk("e_inv5",  32'(o_i5),  32'd1);

      run_req(8'd30);
      chk("e30_ncoin", 32'(got_n), 32'd3);
      chk("e30_c0", 32'(got_codes[0]), 32'(COIN_10));
      chk("e30_c1", 32'(got_codes[1]), 32'(COIN_10));
      chk("e30_c2", 32'(got_codes[2]), 32'(COIN_10));
      chk("e30_short", 32'(got_sh), 32'd0);
      chk("e30_remain", 32'(got_rm), 32'd0);
      @(negedge clk);

      run_req(8'd15);
      chk("e15_ncoin", 32'(got_n), 32'd1);
      chk("e15_c0", 32'(got_codes[0]), 32'(COIN_5));
      chk("e15_short", 32'(got_sh), 32'd1);
      chk("e15_err", 32'(got_er), 32'd0);
      chk("e15_remain", 32'(got_rm), 32'd10);
      @(negedge clk);
      chk("e15_inv5", 32'(o_i5), 32'd0);
      chk("e15_ready", 32'(o_ready), 32'd1);
`ifdef CHG_AUDIT_EN
      chk("audit_short_cnt", 32'(b_sc), 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
